// File: rtl/hdsiso8_prbs_pkg.sv
// ============================================================
// hdsiso8_pkg : shared constants and checker state encoding
// Rev 1.0
// ============================================================
`default_nettype none

package hdsiso8_pkg;

  localparam int                LFSR_W    = 15;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 15'h6000;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h0001;
  localparam int                LOSS_LIM  = 4;
  localparam int                WIN_LEN   = 16;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

endpackage

`default_nettype wire

// File: rtl/hdsiso8_prbs_if.sv
// ============================================================
// hdsiso8_prbs_if : strobe, generator control and checker status bundle
// Rev 1.0
// ============================================================
`default_nettype none

interface hdsiso8_prbs_if;

  logic       step;
  logic       lfsr_en;
  logic       din_sel;
  logic       ext_din;
  logic       siso_dout;
  logic       d_in;
  logic       lfsr_bit;
  logic       lfsr_period;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;

  modport master (
    output step, lfsr_en, din_sel, ext_din, siso_dout,
    input  d_in, lfsr_bit, lfsr_period, locked, err_pulse, err_count
  );

  modport slave (
    input  step, lfsr_en, din_sel, ext_din, siso_dout,
    output d_in, lfsr_bit, lfsr_period, locked, err_pulse, err_count
  );

endinterface

`default_nettype wire

// File: rtl/hdsiso8_prbs_chk.sv
// ============================================================
// hdsiso8_prbs_chk : self-synchronising PRBS checker with loss-of-lock window
// Rev 1.0
// ============================================================
`default_nettype none

module hdsiso8_prbs_chk
  import hdsiso8_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       step_i,
  input  wire logic       siso_dout_i,
  output logic            locked_o,
  output logic            err_pulse_o,
  output logic [7:0]      err_count_o
);

  localparam int CNT_W  = $clog2(LFSR_W);
  localparam int LOSS_W = $clog2(LOSS_LIM + 1);
  localparam int WIN_W  = $clog2(WIN_LEN);

  chk_state_e          state_q;
  logic [LFSR_W-1:0]   c_q;
  logic [LFSR_W-1:0]   c_d;
  logic [CNT_W-1:0]    fill_q;
  logic [CNT_W-1:0]    match_q;
  logic [LOSS_W-1:0]   loss_q;
  logic [LOSS_W-1:0]   loss_d;
  logic [WIN_W-1:0]    win_q;
  logic                locked_q;
  logic                err_pulse_q;
  logic [7:0]          err_count_q;

  logic                exp_bit;
  logic                mis;
  logic                c_zero;

  // Prediction uses the history before the incoming bit is shifted in
  assign exp_bit = ^(c_q & LFSR_TAPS);
  assign mis     = siso_dout_i ^ exp_bit;
  assign c_zero  = (c_q == '0);
  assign c_d     = {c_q[LFSR_W-2:0], siso_dout_i};
  assign loss_d  = loss_q + {{(LOSS_W-1){1'b0}}, mis};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      c_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      loss_q      <= '0;
      win_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (step_i) begin
        c_q <= c_d;
        unique case (state_q)
          HUNT: begin
            if (fill_q == CNT_W'(LFSR_W - 1)) begin
              state_q <= VERIFY;
              fill_q  <= '0;
              match_q <= '0;
            end else begin
              fill_q <= fill_q + 1'b1;
            end
          end
          VERIFY: begin
            if (mis || c_zero) begin
              match_q <= '0;
            end else if (match_q == CNT_W'(LFSR_W - 1)) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              match_q  <= '0;
              win_q    <= '0;
              loss_q   <= '0;
            end else begin
              match_q <= match_q + 1'b1;
            end
          end
          LOCKED: begin
            // The mismatch is counted even on the step that drops lock
            if (mis) begin
              err_pulse_q <= 1'b1;
              if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
              end
            end
            win_q <= win_q + 1'b1;
            if (c_zero || (loss_d >= LOSS_W'(LOSS_LIM))) begin
              state_q  <= HUNT;
              locked_q <= 1'b0;
              fill_q   <= '0;
              loss_q   <= '0;
            end else if (win_q == WIN_W'(WIN_LEN - 1)) begin
              loss_q <= '0;
            end else begin
              loss_q <= loss_d;
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
            fill_q   <= '0;
          end
        endcase
      end
    end
  end

  assign locked_o    = locked_q;
  assign err_pulse_o = err_pulse_q;
  assign err_count_o = err_count_q;

endmodule

`default_nettype wire

// File: rtl/hdsiso8_prbs.sv
// ============================================================
// hdsiso8_prbs : PRBS-15 generator, d_in source mux and checker wrapper
// Rev 1.0
// ============================================================
`default_nettype none

module hdsiso8_prbs
  import hdsiso8_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     rst_n,
  hdsiso8_prbs_if.slave bus
);

  logic [LFSR_W-1:0] g_q;
  logic [LFSR_W-1:0] g_d;
  logic              fb;
  logic              lfsr_period_q;

  assign fb = ^(g_q & LFSR_TAPS);

  // An all-zero state would lock up the LFSR, so it reloads without waiting for a step
  always_comb begin
    g_d = g_q;
    if (g_q == '0) begin
      g_d = LFSR_SEED;
    end else if (bus.step && bus.lfsr_en) begin
      g_d = {g_q[LFSR_W-2:0], fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q           <= LFSR_SEED;
      lfsr_period_q <= 1'b1;
    end else begin
      g_q           <= g_d;
      lfsr_period_q <= (g_d == LFSR_SEED);
    end
  end

  assign bus.lfsr_bit    = g_q[LFSR_W-1];
  assign bus.lfsr_period = lfsr_period_q;
  assign bus.d_in        = bus.din_sel ? g_q[LFSR_W-1] : bus.ext_din;

  hdsiso8_prbs_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .step_i      (bus.step),
    .siso_dout_i (bus.siso_dout),
    .locked_o    (bus.locked),
    .err_pulse_o (bus.err_pulse),
    .err_count_o (bus.err_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_hdsiso8_prbs.sv
// ============================================================
// tb_hdsiso8_prbs : directed self-checking bench for hdsiso8_prbs
// Rev 1.0
// ============================================================
`default_nettype none

module tb_hdsiso8_prbs;

  logic clk;
  logic rst_n;

  hdsiso8_prbs_if bus ();

  hdsiso8_prbs dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          m;
  logic [10:0] dly;
  logic        flip;
  logic        inv;
  logic        zero_line;
  int          pulse_at[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clk cycle; with s=1 it is a serial step fed from the 11-stage loopback model
  task automatic do_step(input logic s);
    logic cur;
    @(negedge clk);
    bus.step      = s;
    bus.siso_dout = zero_line ? 1'b0 : (dly[10] ^ flip ^ inv);
    cur           = bus.d_in;
    @(posedge clk);
    #1;
    if (bus.err_pulse) pulse_at.push_back(m);
    if (s) begin
      dly = {dly[9:0], cur};
      m++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    bus.step  = 1'b0;
    dly       = '0;
    m         = 0;
    flip      = 1'b0;
    inv       = 1'b0;
    zero_line = 1'b0;
    pulse_at.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int  pcnt;
    logic seen_lock;
    checks        = 0;
    errors        = 0;
    m             = 0;
    dly           = '0;
    flip          = 1'b0;
    inv           = 1'b0;
    zero_line     = 1'b0;
    rst_n         = 1'b1;
    bus.step      = 1'b0;
    bus.lfsr_en   = 1'b1;
    bus.din_sel   = 1'b1;
    bus.ext_din   = 1'b1;
    bus.siso_dout = 1'b0;

    // Reset values, taken before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_d_in",        32'(bus.d_in),        32'd0);
    chk("rst_lfsr_bit",    32'(bus.lfsr_bit),    32'd0);
    chk("rst_lfsr_period", 32'(bus.lfsr_period), 32'd1);
    chk("rst_locked",      32'(bus.locked),      32'd0);
    chk("rst_err_pulse",   32'(bus.err_pulse),   32'd0);
    chk("rst_err_count",   32'(bus.err_count),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) do_step(1'b1);
    chk("period_after3",   32'(bus.lfsr_period), 32'd0);
    chk("bit_after3",      32'(bus.lfsr_bit),    32'd0);

    // Generator control: freeze, advance to g=0x2000 then 0x4001
    apply_reset();
    bus.lfsr_en = 1'b0;
    for (int i = 0; i < 5; i++) do_step(1'b1);
    chk("frozen_period", 32'(bus.lfsr_period), 32'd1);
    bus.lfsr_en = 1'b1;
    for (int i = 0; i < 13; i++) do_step(1'b1);
    for (int i = 0; i < 3; i++) do_step(1'b0);
    chk("bit_after13",    32'(bus.lfsr_bit),    32'd0);
    chk("period_after13", 32'(bus.lfsr_period), 32'd0);
    do_step(1'b1);
    chk("bit_after14",    32'(bus.lfsr_bit),    32'd1);
    @(negedge clk);
    bus.step    = 1'b0;
    bus.din_sel = 1'b0;
    bus.ext_din = 1'b0;
    #1 chk("ext_din0", 32'(bus.d_in), 32'd0);
    bus.ext_din = 1'b1;
    #1 chk("ext_din1", 32'(bus.d_in), 32'd1);
    bus.ext_din = 1'b0;
    #1 chk("ext_din0b", 32'(bus.d_in), 32'd0);
    bus.din_sel = 1'b1;
    #1 chk("sel_lfsr", 32'(bus.d_in), 32'd1);

    // Zero state reloads the seed on the next edge, without a step
    @(negedge clk);
    force dut.g_q = '0;
    #1 release dut.g_q;
    @(posedge clk);
    #1;
    chk("g_reload",        32'(dut.g_q),         32'h0001);
    chk("reload_period",   32'(bus.lfsr_period), 32'd1);

    // Loopback: lock after step 40 (30th valid bit), period 32767
    apply_reset();
    pcnt = 0;
    for (int i = 0; i < 32800; i++) begin
      do_step(1'b1);
      chk("lb_locked", 32'(bus.locked),      32'(i >= 40));
      chk("lb_period", 32'(bus.lfsr_period), 32'((i % 32767) == 32766));
      if (bus.lfsr_period) pcnt++;
    end
    chk("lb_period_count", 32'(pcnt),          32'd1);
    chk("lb_err_count",    32'(bus.err_count), 32'd0);
    chk("lb_pulses",       32'(pulse_at.size()), 32'd0);

    // Single-bit flip at step 60: pulses at 60, 74, 75
    apply_reset();
    while (m < 60) do_step(1'b1);
    chk("flip_pre_locked", 32'(bus.locked), 32'd1);
    flip = 1'b1;
    do_step(1'b1);
    flip = 1'b0;
    while (m < 110) do_step(1'b1);
    chk("flip_npulse", 32'(pulse_at.size()), 32'd3);
    if (pulse_at.size() == 3) begin
      chk("flip_p0", 32'(pulse_at[0]), 32'd60);
      chk("flip_p1", 32'(pulse_at[1]), 32'd74);
      chk("flip_p2", 32'(pulse_at[2]), 32'd75);
    end
    chk("flip_err_count", 32'(bus.err_count), 32'd3);
    chk("flip_locked",    32'(bus.locked),    32'd1);

    // Inverted stream from step 57 (start of a loss window): unlock after 4 errors
    apply_reset();
    while (m < 57) do_step(1'b1);
    chk("inv_pre_locked", 32'(bus.locked), 32'd1);
    inv = 1'b1;
    for (int i = 0; i < 3; i++) do_step(1'b1);
    chk("inv_locked_3", 32'(bus.locked),    32'd1);
    chk("inv_errs_3",   32'(bus.err_count), 32'd3);
    do_step(1'b1);
    chk("inv_locked_4", 32'(bus.locked),    32'd0);
    chk("inv_errs_4",   32'(bus.err_count), 32'd4);
    seen_lock = 1'b0;
    for (int i = 0; i < 300; i++) begin
      do_step(1'b1);
      if (bus.locked) seen_lock = 1'b1;
    end
    chk("inv_no_relock",  32'(seen_lock),       32'd0);
    chk("inv_err_final",  32'(bus.err_count),   32'd4);
    chk("inv_npulse",     32'(pulse_at.size()), 32'd4);
    if (pulse_at.size() == 4) begin
      chk("inv_p0", 32'(pulse_at[0]), 32'd57);
      chk("inv_p3", 32'(pulse_at[3]), 32'd60);
    end

    // Asynchronous reset mid-sequence, sampled before the next rising edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_err_count", 32'(bus.err_count), 32'd0);
    chk("async_locked",    32'(bus.locked),    32'd0);
    chk("async_period",    32'(bus.lfsr_period), 32'd1);

    // Constant-0 line must never lock
    apply_reset();
    zero_line = 1'b1;
    seen_lock = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      do_step(1'b1);
      if (bus.locked) seen_lock = 1'b1;
    end
    chk("zero_no_lock",   32'(seen_lock),     32'd0);
    chk("zero_err_count", 32'(bus.err_count), 32'd0);

    @(negedge clk);
    bus.step = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
